// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded-instruction records into 16-bit Thumb words and streams them to memory via a 2-entry FIFO.
// Define ENC_RANGE_CHECK_EN to reject out-of-range records and raise the sticky err_illegal flag.
module instr_encoder #(
    parameter int              ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              restart,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        opcode,
    input  logic [3:0]        reg1,
    input  logic [3:0]        reg2,
    input  logic [3:0]        reg3,
    input  logic [15:0]       offset,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic              mem_ready,
    output logic [15:0]       word_count,
    output logic              err_illegal
);
    typedef enum logic [3:0] {
        OP_PUSH, OP_POP, OP_SUB_SP, OP_CMP, OP_MOVS, OP_MOV, OP_LDR, OP_STR,
        OP_LDR_NOP, OP_ADD_SP, OP_BRANCH_NC, OP_ADDS_3OP, OP_BRANCH_C, OP_STRB, OP_LDRB, OP_ADDS_2OP
    } op_e;

    logic [15:0] fifo [2];
    logic        wr_ptr, rd_ptr;
    logic [1:0]  count;
    logic [15:0] word;
    logic        illegal, accept, push, pop;
    logic [2:0]  rd, rs, ro;

    assign rd = reg3[2:0];
    assign rs = reg2[2:0];
    assign ro = reg1[2:0];

    always_comb begin
        word = 16'h0000;
        case (op_e'(opcode))
            OP_PUSH:      word = 16'hB580;
            OP_POP:       word = 16'hBD80;
            OP_SUB_SP:    word = 16'hB080 | {9'd0, offset[8:2]};
            OP_CMP:       word = 16'h2800 | {5'd0, rd, offset[7:0]};
            OP_MOVS:      word = 16'h2000 | {5'd0, rd, offset[7:0]};
            OP_MOV:       word = 16'h4600 | {8'd0, reg3[3], reg2[3], rs, rd};
            OP_LDR:       word = 16'h4800 | {5'd0, rd, offset[9:2]};
            OP_STR:       word = 16'h6000 | {5'd0, offset[4:0], rs, rd};
            OP_LDR_NOP:   word = 16'h6800 | {5'd0, offset[4:0], rs, rd};
            OP_ADD_SP:    word = 16'hA800 | {5'd0, rd, offset[9:2]};
            OP_BRANCH_NC: word = 16'hE000 | {5'd0, offset[11:1]};
            OP_ADDS_3OP:  word = 16'h1C00 | {7'd0, offset[2:0], rs, rd};
            OP_BRANCH_C:  word = 16'hD000 | {4'd0, reg1, offset[7:0]};
            OP_STRB:      word = 16'h5400 | {7'd0, ro, rs, rd};
            OP_LDRB:      word = 16'h5C00 | {7'd0, ro, rs, rd};
            OP_ADDS_2OP:  word = 16'h3000 | {5'd0, rd, offset[7:0]};
            default:      word = 16'h0000;
        endcase
    end

`ifdef ENC_RANGE_CHECK_EN
    always_comb begin
        illegal = 1'b0;
        case (op_e'(opcode))
            OP_SUB_SP:            illegal = offset > 16'd508 || offset[1:0] != 2'd0;
            OP_LDR, OP_ADD_SP:    illegal = offset > 16'd1020 || offset[1:0] != 2'd0;
            OP_BRANCH_NC:         illegal = offset[0] || offset > 16'd4094;
            OP_STR, OP_LDR_NOP:   illegal = offset > 16'd31;
            OP_ADDS_3OP:          illegal = offset > 16'd7;
            OP_CMP, OP_MOVS:      illegal = offset > 16'd255;
            OP_BRANCH_C:          illegal = offset > 16'd255 || reg1 >= 4'hE;
            OP_ADDS_2OP:          illegal = offset > 16'd255 || offset[0];
            OP_MOV:               illegal = !reg2[3] && !reg3[3];
            default:              illegal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_illegal <= 1'b0;
        else if (restart)
            err_illegal <= 1'b0;
        else if (accept && illegal)
            err_illegal <= 1'b1;
    end
`else
    assign illegal     = 1'b0;
    assign err_illegal = 1'b0;
`endif

    // in_ready comes from the registered count, so a full FIFO never accepts even while popping
    assign in_ready  = count != 2'd2;
    assign mem_we    = count != 2'd0;
    assign mem_wdata = fifo[rd_ptr];
    assign accept    = in_valid && in_ready && !restart;
    assign push      = accept && !illegal;
    assign pop       = mem_we && mem_ready && !restart;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo[0]    <= 16'h0000;
            fifo[1]    <= 16'h0000;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count      <= 2'd0;
            mem_addr   <= BASE_ADDR;
            word_count <= 16'h0000;
        end else if (restart) begin
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count      <= 2'd0;
            mem_addr   <= BASE_ADDR;
            word_count <= 16'h0000;
        end else begin
            if (push) begin
                fifo[wr_ptr] <= word;
                wr_ptr       <= !wr_ptr;
            end
            if (pop) begin
                rd_ptr     <= !rd_ptr;
                mem_addr   <= mem_addr + ADDR_W'(2);
                word_count <= word_count + 16'd1;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the instruction decode block: accepts one decoded-instruction record (opcode, reg1/reg2/reg3, offset) per handshake and packs it into a 16-bit Thumb instruction word.
- Streams encoded words into instruction memory through a 2-entry output FIFO and a byte-address write counter.
- Sits between the program loader / test generator and instruction memory.

Parameters:
- ADDR_W, 16, instruction-memory byte-address width
- BASE_ADDR, 16'h0000, first write address after reset or restart; must be even

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- restart  input  1  sync pulse: reload address to BASE_ADDR, flush FIFO
- in_valid  input  1  record valid
- in_ready  output  1  record accepted when in_valid && in_ready
- opcode  input  4  0 push, 1 pop, 2 sub_sp, 3 cmp, 4 movs, 5 mov, 6 ldr, 7 str, 8 ldr_nop, 9 add_sp, 10 branch_nc, 11 adds_3op, 12 branch_c, 13 strb, 14 ldrb, 15 adds_2op
- reg1  input  4  offset register (strb/ldrb) or condition code (branch_c)
- reg2  input  4  source/base register
- reg3  input  4  destination register
- offset  input  16  immediate in decoder units (bytes for sp/pc/branch forms)
- mem_we  output  1  write strobe
- mem_addr  output  ADDR_W  byte address, increments by 2
- mem_wdata  output  16  encoded word
- mem_ready  input  1  memory accepts write when mem_we && mem_ready
- word_count  output  16  words written since reset/restart, wraps
- err_illegal  output  1  sticky illegal-record flag (feature only)

Behaviour:
- Reset: in_ready=1, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, word_count=0, err_illegal=0, FIFO empty.
- Encoding (rd=reg3[2:0], rs=reg2[2:0], ro=reg1[2:0]):
  push B580; pop BD80; sub_sp B080|offset[8:2]; cmp 2800|rd<<8|offset[7:0]; movs 2000|rd<<8|offset[7:0];
  mov 4600|reg3[3]<<7|reg2[3]<<6|rs<<3|rd; ldr 4800|rd<<8|offset[9:2]; str 6000|offset[4:0]<<6|rs<<3|rd;
  ldr_nop 6800|same fields as str; add_sp A800|rd<<8|offset[9:2]; branch_nc E000|offset[11:1];
  adds_3op 1C00|offset[2:0]<<6|rs<<3|rd; branch_c D000|reg1<<8|offset[7:0]; strb 5400|ro<<6|rs<<3|rd;
  ldrb 5C00|ro<<6|rs<<3|rd; adds_2op 3000|rd<<8|offset[7:0].
- Pipeline: accepted record encoded combinationally, written to FIFO same edge; word presented on mem_* from FIFO head next cycle. Latency accept-to-mem_we = 1 cycle.
- FIFO 2 entries; in_ready = !full. Simultaneous push and pop when full: pop frees slot, in_ready evaluated on registered count (no accept that cycle).
- mem_we = FIFO non-empty. On mem_we && mem_ready: pop, mem_addr += 2 (wraps at 2^ADDR_W), word_count += 1 (wraps 16'hFFFF→0).
- mem_addr, mem_wdata stable while mem_we && !mem_ready.
- restart has priority over handshake that cycle: FIFO cleared, mem_we=0 next cycle, address=BASE_ADDR, word_count=0; record offered the same cycle is dropped; err_illegal cleared.
- Async reset mid-transfer: all state to reset values immediately; partially stalled write abandoned.

Optional Feature:
- ENC_RANGE_CHECK_EN defined: record is illegal if any of — sub_sp offset >508 or offset[1:0]≠0; ldr/add_sp offset >1020 or misaligned; branch_nc offset[0]≠0 or >4094; str/ldr_nop offset >31; adds_3op offset >7; 8-bit-imm forms offset >255; mov with reg2[3]=reg3[3]=0; branch_c reg1 ≥ 4'hE; adds_2op offset[0]=1. Illegal record accepted (in_ready honoured) but not written; err_illegal set, sticky until reset/restart.
- Undefined: no checks; fields silently truncated per encoding table; err_illegal tied 0.

Test Plan:
- Reset, push {opcode 0}, mem_ready=1 -> next cycle mem_we=1, mem_addr=0000, mem_wdata=B580; word_count=1 after.
- Stream cmp r3,#7 / branch_nc off 0x10 / ldrb ro=2 rs=1 rd=0 -> words 2B07, E008, 5C88 at addrs 0,2,4.
- mem_ready=0 while sending 3 records -> two accepted, in_ready=0 on third, mem_wdata held; release -> all three written in order.
- restart asserted with 2 words queued -> mem_we=0 next cycle, mem_addr=BASE_ADDR, word_count=0, nothing written.
- ENC_RANGE_CHECK_EN: sub_sp offset 0x202 -> no write, err_illegal=1; following movs r1,#5 still writes 2105.
- Feature off: str offset 0x25 -> 6000|(5<<6)|rs<<3|rd written, err_illegal=0.
